// File: rtl/ahb_pkg.sv
// Shared AHB-2 encodings and burst helpers for the bus arbiter slice.
package ahb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8  = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {OKAY = 2'd0, ERROR = 2'd1, RETRY = 2'd2, SPLIT = 2'd3} hresp_t;

  typedef enum logic [1:0] {ARB, BURST, LOCK} arb_state_t;

  localparam int unsigned CNT_W = 4;

  // Fixed-length bursts report their beat count; SINGLE/INCR report 0.
  function automatic int burst_beats(hburst_t b);
    case (b)
      WRAP4, INCR4:   return 4;
      WRAP8, INCR8:   return 8;
      WRAP16, INCR16: return 16;
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority encoder: first requester after ptr (wrapping) wins.
module ahb_rr_picker #(
  parameter int N  = 4,
  parameter int MW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [MW-1:0] idx,
  output logic          any
);

  logic [MW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = MW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-2 multi-master arbiter: round-robin grant with burst and lock holding.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]          ptr_q, ptr_d, gidx_q, gidx_d, hmaster_d;
  logic [MW-1:0]          p_idx, pick_idx;
  logic [NUM_MASTERS-1:0] p_gnt, pick_gnt, hgrant_d;
  logic                   p_any, hmastlock_d, tail_q, tail_d, pend_q, pend_d;
  logic                   lock_req, retry_rsp, repick;
  htrans_t                trans;
  int                     beats;

  ahb_rr_picker #(.N(NUM_MASTERS), .MW(MW)) u_pick (
    .req   (HBUSREQ),
    .ptr   (ptr_q),
    .grant (p_gnt),
    .idx   (p_idx),
    .any   (p_any)
  );

  assign pick_gnt  = p_any ? p_gnt : DEF_GNT;
  assign pick_idx  = p_any ? p_idx : DEF_IDX;
  assign trans     = htrans_t'(HTRANS);
  assign beats     = burst_beats(hburst_t'(HBURST));
  assign lock_req  = HLOCK[gidx_q] & HBUSREQ[gidx_q];
  assign retry_rsp = hresp_t'(HRESP) inside {RETRY, SPLIT};

  // tail_q holds the grant one more cycle after a lock releases; pend_q marks
  // the first RETRY/SPLIT cycle so the abort lands on the second.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    pend_d      = 1'b0;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    hgrant_d    = HGRANT;
    hmaster_d   = HMASTER;
    hmastlock_d = HMASTLOCK;
    repick      = 1'b0;
    if (pend_q) begin
      state_d = ARB;
      cnt_d   = '0;
      tail_d  = 1'b0;
      if (HREADY) begin
        hmaster_d   = gidx_q;
        hmastlock_d = lock_req;
        repick      = 1'b1;
      end
    end else if (!HREADY) begin
      pend_d = retry_rsp;
    end else begin
      hmaster_d   = gidx_q;
      hmastlock_d = lock_req | (state_q == LOCK);
      case (state_q)
        ARB: begin
          if (tail_q) begin
            tail_d = 1'b0;
          end else if (lock_req) begin
            state_d = LOCK;
          end else if (trans == NONSEQ && beats > 1) begin
            state_d = BURST;
            cnt_d   = CNT_W'(beats - 1);
          end else begin
            repick = 1'b1;
          end
        end
        BURST: begin
          if (trans == IDLE || trans == NONSEQ) begin
            state_d = ARB;
            cnt_d   = '0;
          end else if (trans == SEQ) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = ARB;
              cnt_d   = '0;
              repick  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        LOCK: begin
          if (!lock_req) begin
            state_d = ARB;
            tail_d  = 1'b1;
          end
        end
        default: state_d = ARB;
      endcase
    end
    if (repick) begin
      hgrant_d = pick_gnt;
      gidx_d   = pick_idx;
      ptr_d    = pick_idx;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= ARB;
      cnt_q     <= '0;
      ptr_q     <= DEF_IDX;
      gidx_q    <= DEF_IDX;
      tail_q    <= 1'b0;
      pend_q    <= 1'b0;
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      tail_q    <= tail_d;
      pend_q    <= pend_d;
      HGRANT    <= hgrant_d;
      HMASTER   <= hmaster_d;
      HMASTLOCK <= hmastlock_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed and randomized checks of ahb_bus_arbiter against a transaction-level model.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [N-1:0] HBUSREQ, HLOCK, HGRANT;
  logic [1:0]   HTRANS, HRESP, HMASTER;
  logic [2:0]   HBURST;
  logic         HREADY, HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model: who holds the grant, who owns the address phase, and what the
  // current bus activity is (burst progress as beats done out of length).
  int m_gnt, m_own, m_last, m_len, m_done;
  bit m_mlock, m_inburst, m_locked, m_tail, m_retry;
  int burst_len [8] = '{0, 0, 4, 4, 8, 8, 16, 16};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    logic [1:0] b;
    b = 2'(i);
    return v[b];
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (bitof(HBUSREQ, c)) return c;
    end
    return DEF;
  endfunction

  task automatic reassign();
    m_gnt  = rr_pick();
    m_last = m_gnt;
  endtask

  task automatic model_reset();
    m_gnt = DEF; m_own = DEF; m_last = DEF; m_mlock = 1'b0;
    m_inburst = 1'b0; m_len = 0; m_done = 0;
    m_locked = 1'b0; m_tail = 1'b0; m_retry = 1'b0;
  endtask

  task automatic model_step();
    int g;
    bit lr;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    g  = m_gnt;
    lr = bitof(HLOCK, g) && bitof(HBUSREQ, g);
    if (m_retry) begin
      m_retry = 1'b0; m_inburst = 1'b0; m_locked = 1'b0; m_tail = 1'b0;
      if (HREADY) begin
        m_own   = g;
        m_mlock = lr;
        reassign();
      end
    end else if (!HREADY) begin
      m_retry = (HRESP == 2'd2 || HRESP == 2'd3);
    end else begin
      m_own   = g;
      m_mlock = lr || m_locked;
      if (m_locked) begin
        if (!lr) begin
          m_locked = 1'b0;
          m_tail   = 1'b1;
        end
      end else if (m_inburst) begin
        if (HTRANS == 2'd0 || HTRANS == 2'd2) m_inburst = 1'b0;
        else if (HTRANS == 2'd3) begin
          m_done++;
          if (m_done >= m_len) begin
            m_inburst = 1'b0;
            reassign();
          end
        end
      end else if (m_tail) begin
        m_tail = 1'b0;
      end else if (lr) begin
        m_locked = 1'b1;
      end else if (HTRANS == 2'd2 && burst_len[HBURST] > 0) begin
        m_inburst = 1'b1;
        m_len     = burst_len[HBURST];
        m_done    = 1;
      end else begin
        reassign();
      end
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_on) begin
      check("grant",    32'(HGRANT), 32'(1) << m_gnt);
      check("hmaster",  32'(HMASTER), 32'(m_own));
      check("mastlock", 32'(HMASTLOCK), 32'(m_mlock));
      check("onehot",   32'($onehot(HGRANT)), 32'd1);
      check("range",    32'(HMASTER < N), 32'd1);
    end
  end

  task automatic drive(input logic rst_n, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [1:0] rsp);
    HRESETn = rst_n; HBUSREQ = req; HLOCK = lock;
    HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
  endtask

  int t2 [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    logic [3:0] req, lock;
    logic [1:0] tr, rsp;
    logic       rdy;
    int         sel;

    // 1: reset and parking
    do_reset();
    chk_on = 1'b1;
    check("t1_rst_grant", 32'(HGRANT), 32'h1);
    check("t1_rst_master", 32'(HMASTER), 32'h0);
    check("t1_rst_lock", 32'(HMASTLOCK), 32'h0);
    drive(1'b1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_park_grant", 32'(HGRANT), 32'h1);
      check("t1_park_master", 32'(HMASTER), 32'h0);
    end

    // 2: rotation among three SINGLE requesters
    drive(1'b1, 4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_rotate", 32'(HGRANT), 32'(1) << t2[i]);
      if (i > 0) check("t2_owner", 32'(HMASTER), 32'(t2[i-1]));
    end

    // 3: INCR8 from M2 with a wait state before every SEQ beat
    do_reset();
    drive(1'b1, 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    tick();
    check("t3_owner_m2", 32'(HMASTER), 32'h2);
    drive(1'b1, 4'b1110, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0);
    tick();
    check("t3_start_hold", 32'(HGRANT), 32'h4);
    for (int b = 1; b <= 7; b++) begin
      drive(1'b1, 4'b1110, 4'b0000, 2'd3, 3'd5, 1'b0, 2'd0);
      tick();
      check("t3_wait_hold", 32'(HGRANT), 32'h4);
      drive(1'b1, 4'b1110, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
      tick();
      check("t3_beat", 32'(HGRANT), (b == 7) ? 32'h8 : 32'h4);
    end
    check("t3_owner_last", 32'(HMASTER), 32'h2);
    drive(1'b1, 4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    check("t3_owner_m3", 32'(HMASTER), 32'h3);
    check("t3_next_m1", 32'(HGRANT), 32'h2);

    // 4: M1 locked for three transfers, M0/M2 requesting
    do_reset();
    drive(1'b1, 4'b0111, 4'b0010, 2'd2, 3'd0, 1'b1, 2'd0);
    tick();
    check("t4_grant_m1", 32'(HGRANT), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_lock_hold", 32'(HGRANT), 32'h2);
      check("t4_mastlock", 32'(HMASTLOCK), 32'h1);
    end
    drive(1'b1, 4'b0111, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    tick();
    check("t4_drop_hold", 32'(HGRANT), 32'h2);
    check("t4_drop_mlock", 32'(HMASTLOCK), 32'h1);
    tick();
    check("t4_tail_hold", 32'(HGRANT), 32'h2);
    check("t4_tail_mlock", 32'(HMASTLOCK), 32'h0);
    tick();
    check("t4_then_m2", 32'(HGRANT), 32'h4);

    // 5: RETRY during an INCR4 from M1
    do_reset();
    drive(1'b1, 4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    tick();
    drive(1'b1, 4'b1011, 4'b0000, 2'd2, 3'd3, 1'b1, 2'd0);
    tick();
    drive(1'b1, 4'b1011, 4'b0000, 2'd3, 3'd3, 1'b1, 2'd0);
    tick();
    drive(1'b1, 4'b1011, 4'b0000, 2'd3, 3'd3, 1'b0, 2'd2);
    tick();
    check("t5_first_rsp", 32'(HGRANT), 32'h2);
    drive(1'b1, 4'b1011, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd2);
    tick();
    check("t5_regrant_m3", 32'(HGRANT), 32'h8);
    drive(1'b1, 4'b1011, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    check("t5_next_m0", 32'(HGRANT), 32'h1);
    check("t5_owner_m3", 32'(HMASTER), 32'h3);

    // 6: reset in the middle of an INCR8
    do_reset();
    drive(1'b1, 4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    tick();
    drive(1'b1, 4'b0100, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0);
    tick();
    drive(1'b1, 4'b0100, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
    tick();
    tick();
    drive(1'b0, 4'b1110, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
    tick();
    check("t6_rst_grant", 32'(HGRANT), 32'h1);
    check("t6_rst_master", 32'(HMASTER), 32'h0);
    check("t6_rst_mlock", 32'(HMASTLOCK), 32'h0);
    drive(1'b1, 4'b1110, 4'b0000, 2'd0, 3'd5, 1'b1, 2'd0);
    tick();
    check("t6_no_burst", 32'(HGRANT), 32'h2);

    // Randomized traffic, checked every cycle by the compare process
    req  = 4'b0110;
    lock = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) lock = lock ^ (4'b0001 << $urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      tr  = (sel < 2) ? 2'd0 : (sel < 3) ? 2'd1 : (sel < 5) ? 2'd2 : 2'd3;
      rdy = ($urandom_range(0, 4) != 0);
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      drive(($urandom_range(0, 299) != 0), req, lock, tr, 3'($urandom_range(0, 7)), rdy, rsp);
      tick();
    end

    @(negedge HCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
